bc_synth_stage: RTL and testbench
=================================

# bc_synth_stage

One 2x interpolation stage of the synthesis (reconstruction) filter bank. It is the inverse direction of the analysis bank that splits the input into decimated subbands. It takes one low-band sample and two high-band samples per transaction. It outputs two full-rate samples: the 2-phase polyphase interpolation of the low band, plus the high band. Cascading three stages (rate x2, x4, x8) rebuilds the full-rate stream from the four subband outputs.

## Interface
Parameters:
- DW, default 9 (`n+1), sample width, signed two's complement.
- CW, default 9, coefficient width, signed.
- TAPS, default 4, taps per polyphase branch; the prototype filter has 2*TAPS taps.
- COEF, default h = {8,24,40,56,56,40,24,8}, packed, h[i] = COEF[i*CW +: CW]; DC gain per phase is 128.
- SHIFT, default 7, right shift applied after rounding.

Ports:
- clock, in, 1: single clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- in_lo, in, DW: low-band sample.
- in_hi0, in, DW: high-band sample for output phase 0.
- in_hi1, in, DW: high-band sample for output phase 1.
- in_valid, in, 1: input transaction valid.
- in_ready, out, 1: high only in IDLE.
- out, out, DW: full-rate output sample (registered).
- out_valid, out, 1: output valid.
- out_ready, in, 1: downstream accept.

## Operation
- Delay line d[0..TAPS-1] of DW bits.
  - On input accept (in_valid && in_ready): d[0] <= in_lo and d[k] <= d[k-1].
  - in_hi0 and in_hi1 are captured into hi0_r and hi1_r.
- Phase sums: y_p = sum_k h[2k+p]*d[k], for p = 0 and p = 1.
  - Accumulator width is DW+CW+clog2(TAPS), which is 20 bits at defaults.
  - r_p = (y_p + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift (floor).
  - o_p = r_p + hi_p, then reduced to DW bits as set under Configuration.
- FSM states are IDLE, CALC, EMIT0, EMIT1.
  - IDLE: in_ready=1. Accept -> CALC.
  - CALC: out <= o_0, out_valid <= 1 -> EMIT0.
  - EMIT0: hold out while !out_ready. On out_ready: out <= o_1 -> EMIT1.
  - EMIT1: hold out while !out_ready. On out_ready: out_valid <= 0 -> IDLE.
- Outputs are computed from the registered delay line and hi_r. Inputs do not change them during emission.
- in_valid outside IDLE is ignored; the upstream holds it.

## Timing
- Reset (async, reset_n=0):
  - state=IDLE, d[*]=0, hi_r=0, out=0, out_valid=0.
  - in_ready=1 once reset is deasserted.
- Reset mid-emission aborts immediately. Any unsent phase is lost, and the delay line is cleared.
- Latency with out_ready held at 1:
  - Accept at edge N.
  - out_valid rises after edge N+1 (phase 0).
  - Phase 1 appears after edge N+2.
  - IDLE is reached after edge N+3, so in_ready is high again in cycle N+3.
- Maximum throughput is one input per 3 cycles, that is 2 outputs per 3 cycles.
- out and out_valid are stable while out_valid && !out_ready (AXI-style hold).
- out_ready low in CALC has no effect.

## Configuration
- BC_SYNTH_SAT_EN defined: o_p is saturated to [-(2^(DW-1)), 2^(DW-1)-1], which is [-256, 255] at defaults.
- BC_SYNTH_SAT_EN undefined: o_p is truncated to its low DW bits (two's-complement wrap).
- The intermediate r_p is kept at full width in both cases; only the final sum is reduced.

## Test plan
- Impulse: after reset, send in_lo=64, hi=0, then in_lo=0, hi=0. Required outputs are 4, 12, then 20, 28.
- DC with high band:
  - Send in_lo=100 four times with hi=0,0; the fourth transaction outputs 100, 100.
  - Send a fifth transaction with in_hi0=5, in_hi1=-3; it outputs 105, 97.
- Overflow: fill the delay line with in_lo=255, then send hi0=10.
  - With BC_SYNTH_SAT_EN: out=255.
  - Without BC_SYNTH_SAT_EN: out=-247.
- Backpressure: hold out_ready=0 for 5 cycles in EMIT0.
  - out stays at o_0, out_valid stays 1, and in_ready stays 0.
  - After release, o_1 follows on the next edge.
- Reset mid-operation: drop reset_n during EMIT1 with DC=100 loaded.
  - out=0 and out_valid=0 immediately.
  - The next impulse of 64 gives 4, 12, proving the delay line was cleared.
- Ignored input: pulse in_valid with in_lo=50 during EMIT0. The delay line must be unchanged, so the next phase output equals the pre-computed o_1.

Source files
------------

// File: rtl/bc_synth_stage.sv
// bc_synth_stage: one 2x interpolation stage of the synthesis filter bank.
// Consumes one low-band sample plus two high-band samples per transaction
// and emits two full-rate samples: the 2-phase polyphase interpolation of
// the low band, each phase plus its high-band sample.
// Optional feature macro: BC_SYNTH_SAT_EN -- when defined the final sum is
// saturated to the DW-bit signed range, otherwise it wraps (low DW bits).
module bc_synth_stage #(
    parameter int unsigned               DW    = 9,
    parameter int unsigned               CW    = 9,
    parameter int unsigned               TAPS  = 4,
    parameter logic [2*TAPS*CW-1:0]      COEF  = {9'sd8, 9'sd24, 9'sd40, 9'sd56,
                                                  9'sd56, 9'sd40, 9'sd24, 9'sd8},
    parameter int unsigned               SHIFT = 7
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic signed [DW-1:0] in_lo,
    input  logic signed [DW-1:0] in_hi0,
    input  logic signed [DW-1:0] in_hi1,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [DW-1:0] out,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Accumulator width, then one extra bit for the rounding add and two
    // more so that adding the high-band sample can never overflow.
    localparam int unsigned AW = DW + CW + $clog2(TAPS);
    localparam int unsigned SW = AW + 2;
    localparam logic signed [AW:0] RND = (AW+1)'(2 ** (SHIFT - 1));

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_EMIT0,
        ST_EMIT1
    } state_t;

    state_t                r_state;
    logic signed [DW-1:0]  r_d [TAPS];
    logic signed [DW-1:0]  r_hi0;
    logic signed [DW-1:0]  r_hi1;
    logic signed [DW-1:0]  r_out;
    logic                  r_out_valid;

    logic                  w_accept;
    logic signed [CW-1:0]  w_h [2*TAPS];
    logic signed [AW-1:0]  w_y0;
    logic signed [AW-1:0]  w_y1;
    logic signed [AW:0]    w_yr0;
    logic signed [AW:0]    w_yr1;
    logic signed [AW:0]    w_r0;
    logic signed [AW:0]    w_r1;
    logic signed [SW-1:0]  w_s0;
    logic signed [SW-1:0]  w_s1;
    logic signed [DW-1:0]  w_o0;
    logic signed [DW-1:0]  w_o1;

    assign in_ready  = (r_state == ST_IDLE);
    assign w_accept  = in_valid && in_ready;
    assign out       = r_out;
    assign out_valid = r_out_valid;

    // Polyphase branch sums over the registered delay line
    always_comb begin
        w_y0 = '0;
        w_y1 = '0;
        for (int unsigned i = 0; i < 2*TAPS; i++) begin
            w_h[i] = COEF[i*CW +: CW];
        end
        for (int unsigned k = 0; k < TAPS; k++) begin
            w_y0 = w_y0 + AW'(w_h[2*k])   * AW'(r_d[k]);
            w_y1 = w_y1 + AW'(w_h[2*k+1]) * AW'(r_d[k]);
        end
    end

    // Round half up, then arithmetic (floor) shift; kept at full width
    assign w_yr0 = (AW+1)'(w_y0) + RND;
    assign w_yr1 = (AW+1)'(w_y1) + RND;
    assign w_r0  = w_yr0 >>> SHIFT;
    assign w_r1  = w_yr1 >>> SHIFT;
    assign w_s0  = SW'(w_r0) + SW'(r_hi0);
    assign w_s1  = SW'(w_r1) + SW'(r_hi1);

`ifdef BC_SYNTH_SAT_EN
    localparam logic signed [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

    assign w_o0 = (w_s0 > SW'(MAXV)) ? MAXV :
                  (w_s0 < SW'(MINV)) ? MINV : w_s0[DW-1:0];
    assign w_o1 = (w_s1 > SW'(MAXV)) ? MAXV :
                  (w_s1 < SW'(MINV)) ? MINV : w_s1[DW-1:0];
`else
    logic w_unused;

    assign w_o0     = w_s0[DW-1:0];
    assign w_o1     = w_s1[DW-1:0];
    assign w_unused = ^{w_s0[SW-1:DW], w_s1[SW-1:DW]};
`endif

    // Delay line and high-band capture, updated only on an accepted input
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                r_d[k] <= '0;
            end
            r_hi0 <= '0;
            r_hi1 <= '0;
        end else if (w_accept) begin
            r_d[0] <= in_lo;
            for (int unsigned k = 1; k < TAPS; k++) begin
                r_d[k] <= r_d[k-1];
            end
            r_hi0 <= in_hi0;
            r_hi1 <= in_hi1;
        end
    end

    // Sequencer: accept, compute, then emit phase 0 and phase 1 with hold
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_out       <= w_o0;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_EMIT0;
                end
                ST_EMIT0: begin
                    if (out_ready) begin
                        r_out   <= w_o1;
                        r_state <= ST_EMIT1;
                    end
                end
                ST_EMIT1: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bc_synth_stage.sv
// Testbench for bc_synth_stage: directed transactions, a behavioural model
// of the interpolation stage, and a per-cycle compare against that model.
module tb_bc_synth_stage;

    localparam int DW   = 9;
    localparam int TAPS = 4;

    logic                 clock;
    logic                 reset_n;
    logic signed [DW-1:0] in_lo;
    logic signed [DW-1:0] in_hi0;
    logic signed [DW-1:0] in_hi1;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] out;
    logic                 out_valid;
    logic                 out_ready;

    int tests = 0;
    int fails = 0;

    int exp_q[$];
    int got_q[$];
    int mdl_d[TAPS];
    int h[8] = '{8, 24, 40, 56, 56, 40, 24, 8};

    bc_synth_stage dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_lo     (in_lo),
        .in_hi0    (in_hi0),
        .in_hi1    (in_hi1),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int reduce(input int v);
        int m;
`ifdef BC_SYNTH_SAT_EN
        if (v > 255) return 255;
        if (v < -256) return -256;
        return v;
`else
        m = v % 512;
        if (m < 0) m = m + 512;
        if (m >= 256) m = m - 512;
        return m;
`endif
    endfunction

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic checkb(input string name, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int k = 0; k < TAPS; k++) mdl_d[k] = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    // Model: shift the low band in, then each output phase is the rounded
    // weighted sum of the history plus that phase's high-band sample.
    task automatic model_accept(input int lo, input int h0, input int h1);
        int y;
        int hi;
        for (int k = TAPS - 1; k > 0; k--) mdl_d[k] = mdl_d[k-1];
        mdl_d[0] = lo;
        for (int p = 0; p < 2; p++) begin
            y = 0;
            for (int k = 0; k < TAPS; k++) y = y + h[2*k+p] * mdl_d[k];
            hi = (p == 0) ? h0 : h1;
            exp_q.push_back(reduce(floor_div(y + 64, 128) + hi));
        end
    endtask

    // Per-cycle compare; an output is consumed when valid && ready
    always @(negedge clock) begin
        if (reset_n) begin
            if (out_valid === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out: got %0d expected no output", out);
                end else if (out !== DW'(exp_q[0])) begin
                    fails++;
                    $display("FAIL model_out: got %0d expected %0d", out, exp_q[0]);
                end
                tests++;
                if (in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL in_ready_busy: got %b expected 0", in_ready);
                end
                if (out_ready) begin
                    got_q.push_back(int'(out));
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic set_ready(input logic v);
        @(posedge clock);
        #1 out_ready = v;
    endtask

    task automatic send(input int lo, input int h0, input int h1);
        int n = 0;
        @(negedge clock);
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
        end else begin
            in_lo    = DW'(lo);
            in_hi0   = DW'(h0);
            in_hi1   = DW'(h1);
            in_valid = 1'b1;
            @(posedge clock);
            model_accept(lo, h0, h1);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic get2(output int a, output int b);
        int n = 0;
        while (got_q.size() < 2 && n < 40) begin
            @(posedge clock);
            n++;
        end
        if (got_q.size() < 2) begin
            check("get2_timeout", got_q.size(), 2);
            a = -9999;
            b = -9999;
            got_q.delete();
        end else begin
            a = got_q.pop_front();
            b = got_q.pop_front();
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        @(posedge clock);
        #1;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkb("wait_valid", out_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b;
        reset_n   = 1'b0;
        in_lo     = '0;
        in_hi0    = '0;
        in_hi1    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mdl_reset();

        // Reset state
        #12;
        check("rst_out", int'(out), 0);
        checkb("rst_out_valid", out_valid, 1'b0);
        #6 reset_n = 1'b1;
        #1;
        checkb("rst_in_ready", in_ready, 1'b1);

        // Impulse response
        send(64, 0, 0);
        get2(a, b);
        check("imp_p0", a, 4);
        check("imp_p1", b, 12);
        send(0, 0, 0);
        get2(a, b);
        check("imp_p2", a, 20);
        check("imp_p3", b, 28);

        // DC with high band
        for (int i = 0; i < 4; i++) begin
            send(100, 0, 0);
            get2(a, b);
        end
        check("dc_p0", a, 100);
        check("dc_p1", b, 100);
        send(100, 5, -3);
        get2(a, b);
        check("dc_hi_p0", a, 105);
        check("dc_hi_p1", b, 97);

        // Backpressure in EMIT0
        set_ready(1'b0);
        send(100, 7, -7);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_hold_out", int'(out), 107);
            checkb("bp_hold_valid", out_valid, 1'b1);
            checkb("bp_hold_in_ready", in_ready, 1'b0);
        end
        set_ready(1'b1);
        @(posedge clock);
        #1;
        check("bp_release_p1", int'(out), 93);
        checkb("bp_release_valid", out_valid, 1'b1);
        get2(a, b);
        check("bp_got_p0", a, 107);
        check("bp_got_p1", b, 93);

        // Ignored input during EMIT0
        set_ready(1'b0);
        send(100, 1, 2);
        wait_valid();
        @(posedge clock);
        #1;
        in_lo    = 9'sd50;
        in_valid = 1'b1;
        checkb("ign_in_ready", in_ready, 1'b0);
        @(posedge clock);
        #1 in_valid = 1'b0;
        set_ready(1'b1);
        get2(a, b);
        check("ign_p0", a, 101);
        check("ign_p1", b, 102);
        send(100, 0, 0);
        get2(a, b);
        check("ign_next_p0", a, 100);
        check("ign_next_p1", b, 100);

        // Overflow of the final sum
        for (int i = 0; i < 4; i++) begin
            send(255, 10, 0);
            get2(a, b);
        end
`ifdef BC_SYNTH_SAT_EN
        check("ovf_p0", a, 255);
`else
        check("ovf_p0", a, -247);
`endif
        check("ovf_p1", b, 255);

        // Reset during EMIT1 with DC loaded
        for (int i = 0; i < 3; i++) begin
            send(100, 0, 0);
            get2(a, b);
        end
        set_ready(1'b0);
        send(100, 0, 0);
        wait_valid();
        @(posedge clock);
        #1 out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
        checkb("mid_emit1_valid", out_valid, 1'b1);
        check("mid_emit1_out", int'(out), 100);
        #3 reset_n = 1'b0;
        mdl_reset();
        #1;
        check("mid_rst_out", int'(out), 0);
        checkb("mid_rst_valid", out_valid, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        #2 reset_n = 1'b1;
        out_ready = 1'b1;
        send(64, 0, 0);
        get2(a, b);
        check("post_rst_p0", a, 4);
        check("post_rst_p1", b, 12);

        repeat (5) @(posedge clock);
        check("exp_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
